// File: rtl/seq_divider_ctrl_if.sv
// Start/done handshake and operand/result bus shared by the CPU sequencer
// and the sequential divider.
interface seq_divider_ctrl_if #(parameter int N = 8);
  logic         St;
  logic [N-1:0] Dividend;
  logic [N-1:0] Divisor;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         Idle;
  logic         Done;
  logic         DivZero;

  modport master (output St, Dividend, Divisor,
                  input  Quotient, Remainder, Idle, Done, DivZero);
  modport slave  (input  St, Dividend, Divisor,
                  output Quotient, Remainder, Idle, Done, DivZero);
endinterface

// File: rtl/seq_divider_ctrl.sv
// Sequential unsigned restoring divider: one quotient bit per shift/subtract
// cycle pair, St/Idle/Done handshake matching the shift-add multiplier.
module seq_divider_ctrl #(
  parameter int N = 8
) (
  input  logic              Clk,
  input  logic              reset,
  seq_divider_ctrl_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] SUB   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [N:0]    a;
  logic [N-1:0]  q;
  logic [N-1:0]  b;
  logic [CW-1:0] cnt;
  logic [N-1:0]  quotient;
  logic [N-1:0]  remainder;
  logic          div_zero;

  logic [N:0]    diff;
  logic [N:0]    a_nxt;
  logic [N-1:0]  q_nxt;

  // Trial subtraction; a set MSB means the divisor did not fit, so restore.
  always_comb begin
    diff  = a - {1'b0, b};
    a_nxt = a;
    q_nxt = q;
    if (!diff[N]) begin
      a_nxt = diff;
      q_nxt = {q[N-1:1], 1'b1};
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a         <= '0;
      q         <= '0;
      b         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.St) begin
            if (bus.Divisor != '0) begin
              a        <= '0;
              q        <= bus.Dividend;
              b        <= bus.Divisor;
              cnt      <= '0;
              div_zero <= 1'b0;
              state    <= SHIFT;
            end else begin
              quotient  <= '1;
              remainder <= bus.Dividend;
              div_zero  <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          {a, q} <= {a[N-1:0], q, 1'b0};
          state  <= SUB;
        end
        SUB: begin
          a   <= a_nxt;
          q   <= q_nxt;
          cnt <= cnt + CW'(1);
          // Results publish on the last subtract so they stay stable in flight.
          if (cnt == LAST) begin
            quotient  <= q_nxt;
            remainder <= a_nxt[N-1:0];
            state     <= DONE;
          end else begin
            state <= SHIFT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Idle      = (state == IDLE);
  assign bus.Done      = (state == DONE);
  assign bus.Quotient  = quotient;
  assign bus.Remainder = remainder;
  assign bus.DivZero   = div_zero;
endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Randomized self-checking bench for seq_divider_ctrl (N=8) against an
// integer-division reference model.
module tb_seq_divider_ctrl;
  localparam int N   = 8;
  localparam int LAT = 2 * N + 1;

  logic Clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  seq_divider_ctrl_if #(.N(N)) bus ();
  seq_divider_ctrl #(.N(N)) dut (.Clk(Clk), .reset(reset), .bus(bus));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: plain integer division, divide-by-zero convention.
  function automatic void ref_div(input int dvd, input int dvs,
                                  output int eq, output int er, output bit ez);
    if (dvs == 0) begin eq = 255; er = dvd; ez = 1'b1; end
    else begin eq = dvd / dvs; er = dvd % dvs; ez = 1'b0; end
  endfunction

  // Drive one operation; lat = negedges after the accepting edge until Done.
  task automatic do_op(input logic [N-1:0] dvd, input logic [N-1:0] dvs, output int lat);
    int w = 0;
    while (!bus.Idle && w < 64) begin @(negedge Clk); w++; end
    checks++;
    if (!bus.Idle) begin errors++; $display("FAIL idle_wait: Idle=%b required 1", bus.Idle); end
    bus.St = 1'b1; bus.Dividend = dvd; bus.Divisor = dvs;
    @(posedge Clk);
    @(negedge Clk);
    bus.St = 1'b0; bus.Dividend = N'($urandom); bus.Divisor = N'($urandom);
    lat = 1;
    while (!bus.Done && lat < 64) begin @(negedge Clk); lat++; end
  endtask

  task automatic test_reset;
    bus.St = 1'b0; bus.Dividend = '0; bus.Divisor = '0;
    reset = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if (bus.Idle !== 1'b1 || bus.Done !== 1'b0 || bus.Quotient !== '0 ||
        bus.Remainder !== '0 || bus.DivZero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: Idle=%b Done=%b Q=%0d R=%0d DZ=%b required 1 0 0 0 0",
               bus.Idle, bus.Done, bus.Quotient, bus.Remainder, bus.DivZero);
    end
    reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_basic;
    int lat, w;
    bit idle_bad = 1'b0;
    w = 0;
    while (!bus.Idle && w < 64) begin @(negedge Clk); w++; end
    bus.St = 1'b1; bus.Dividend = 8'd100; bus.Divisor = 8'd7;
    @(posedge Clk);
    @(negedge Clk);
    bus.St = 1'b0;
    lat = 1;
    while (!bus.Done && lat < 64) begin
      if (bus.Idle) idle_bad = 1'b1;
      @(negedge Clk); lat++;
    end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL basic_latency: got %0d required %0d", lat, LAT); end
    checks++;
    if (idle_bad) begin errors++; $display("FAIL basic_idle_low: Idle seen 1 required 0 in flight"); end
    checks++;
    if (bus.Quotient !== 8'd14 || bus.Remainder !== 8'd2 || bus.DivZero !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: Q=%0d R=%0d DZ=%b required 14 2 0", bus.Quotient, bus.Remainder, bus.DivZero);
    end
    @(negedge Clk);
    checks++;
    if (bus.Done !== 1'b0 || bus.Idle !== 1'b1) begin
      errors++; $display("FAIL basic_done_pulse: Done=%b Idle=%b required 0 1", bus.Done, bus.Idle);
    end
  endtask

  task automatic test_hold;
    int lat;
    bit held = 1'b1;
    do_op(8'd255, 8'd1, lat);
    checks++;
    if (bus.Quotient !== 8'd255 || bus.Remainder !== 8'd0) begin
      errors++; $display("FAIL hold_first: Q=%0d R=%0d required 255 0", bus.Quotient, bus.Remainder);
    end
    @(negedge Clk);
    bus.St = 1'b1; bus.Dividend = 8'd5; bus.Divisor = 8'd9;
    @(posedge Clk);
    @(negedge Clk);
    bus.St = 1'b0;
    lat = 1;
    while (!bus.Done && lat < 64) begin
      if (bus.Quotient !== 8'd255 || bus.Remainder !== 8'd0) held = 1'b0;
      @(negedge Clk); lat++;
    end
    checks++;
    if (!held) begin errors++; $display("FAIL hold_in_flight: outputs changed before final subtract, required 255 0"); end
    checks++;
    if (bus.Quotient !== 8'd0 || bus.Remainder !== 8'd5 || lat != LAT) begin
      errors++; $display("FAIL hold_second: Q=%0d R=%0d lat=%0d required 0 5 %0d", bus.Quotient, bus.Remainder, lat, LAT);
    end
  endtask

  task automatic test_divzero;
    int lat;
    do_op(8'd42, 8'd0, lat);
    checks++;
    if (lat != 1 || bus.Quotient !== 8'hFF || bus.Remainder !== 8'd42 || bus.DivZero !== 1'b1) begin
      errors++;
      $display("FAIL divzero: lat=%0d Q=%0d R=%0d DZ=%b required 1 255 42 1", lat, bus.Quotient, bus.Remainder, bus.DivZero);
    end
    @(negedge Clk);
    checks++;
    if (bus.Done !== 1'b0 || bus.DivZero !== 1'b1) begin
      errors++; $display("FAIL divzero_hold: Done=%b DZ=%b required 0 1", bus.Done, bus.DivZero);
    end
    do_op(8'd200, 8'd16, lat);
    checks++;
    if (lat != LAT || bus.Quotient !== 8'd12 || bus.Remainder !== 8'd8 || bus.DivZero !== 1'b0) begin
      errors++;
      $display("FAIL after_divzero: lat=%0d Q=%0d R=%0d DZ=%b required %0d 12 8 0", lat, bus.Quotient, bus.Remainder, bus.DivZero, LAT);
    end
  endtask

  task automatic test_ignore_st;
    int dones = 0;
    @(negedge Clk);
    bus.St = 1'b1; bus.Dividend = 8'd100; bus.Divisor = 8'd7;
    @(posedge Clk);
    @(negedge Clk);
    bus.St = 1'b0; bus.Dividend = 8'd9; bus.Divisor = 8'd3;
    for (int c = 1; c <= 30; c++) begin
      bus.St = (c == 3 || c == 10);
      if (bus.Done) begin
        dones++;
        checks++;
        if (c != LAT || bus.Quotient !== 8'd14 || bus.Remainder !== 8'd2) begin
          errors++;
          $display("FAIL ignore_st_result: cycle=%0d Q=%0d R=%0d required %0d 14 2", c, bus.Quotient, bus.Remainder, LAT);
        end
      end
      @(negedge Clk);
    end
    bus.St = 1'b0;
    checks++;
    if (dones != 1) begin errors++; $display("FAIL ignore_st_dones: got %0d required 1", dones); end
  endtask

  task automatic test_back_to_back;
    int last = -1, ndone = 0, idles = 0;
    @(negedge Clk);
    bus.St = 1'b1; bus.Dividend = 8'd200; bus.Divisor = 8'd10;
    for (int c = 0; c < 75; c++) begin
      @(negedge Clk);
      if (bus.Idle) idles++;
      if (bus.Done) begin
        checks++;
        if (bus.Quotient !== 8'd20 || bus.Remainder !== 8'd0) begin
          errors++; $display("FAIL b2b_result: Q=%0d R=%0d required 20 0", bus.Quotient, bus.Remainder);
        end
        if (last >= 0) begin
          checks++;
          if (c - last != 2 * N + 2 || idles != 1) begin
            errors++; $display("FAIL b2b_period: period=%0d idles=%0d required %0d 1", c - last, idles, 2 * N + 2);
          end
        end
        last = c; idles = 0; ndone++;
      end
    end
    bus.St = 1'b0;
    checks++;
    if (ndone < 3) begin errors++; $display("FAIL b2b_count: got %0d required >=3", ndone); end
    repeat (40) @(negedge Clk);
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge Clk);
    bus.St = 1'b1; bus.Dividend = 8'd77; bus.Divisor = 8'd5;
    @(posedge Clk);
    @(negedge Clk);
    bus.St = 1'b0;
    repeat (3) @(negedge Clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.Idle !== 1'b1 || bus.Done !== 1'b0 || bus.Quotient !== '0 ||
        bus.Remainder !== '0 || bus.DivZero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: Idle=%b Done=%b Q=%0d R=%0d DZ=%b required 1 0 0 0 0",
               bus.Idle, bus.Done, bus.Quotient, bus.Remainder, bus.DivZero);
    end
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    do_op(8'd77, 8'd5, lat);
    checks++;
    if (lat != LAT || bus.Quotient !== 8'd15 || bus.Remainder !== 8'd2) begin
      errors++; $display("FAIL after_reset: lat=%0d Q=%0d R=%0d required %0d 15 2", lat, bus.Quotient, bus.Remainder, LAT);
    end
  endtask

  task automatic test_random;
    int lat, eq, er, dvd, dvs;
    bit ez;
    for (int i = 0; i < 1000; i++) begin
      dvd = $urandom_range(0, 255);
      dvs = $urandom_range(1, 255);
      case (i % 10)
        0: dvd = 0;
        1: dvs = 1;
        2: dvs = 255;
        3: dvs = 0;
        4: dvd = 255;
        default: ;
      endcase
      ref_div(dvd, dvs, eq, er, ez);
      do_op(N'(dvd), N'(dvs), lat);
      checks++;
      if (lat != (ez ? 1 : LAT) || bus.Quotient !== N'(eq) || bus.Remainder !== N'(er) || bus.DivZero !== ez) begin
        errors++;
        $display("FAIL rand %0d/%0d: lat=%0d Q=%0d R=%0d DZ=%b required %0d %0d %0d %b",
                 dvd, dvs, lat, bus.Quotient, bus.Remainder, bus.DivZero, ez ? 1 : LAT, eq, er, ez);
      end
      @(negedge Clk);
      checks++;
      if (bus.Done !== 1'b0) begin errors++; $display("FAIL rand_pulse: Done=%b required 0", bus.Done); end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_basic();
    test_hold();
    test_divzero();
    test_ignore_st();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
